// File: rtl/rmw_unit.sv
// Read-modify-write sequencer: reads a byte, runs it through the external ALU, writes it back.
// Optional macro RMW_DUMMY_WRITE_EN adds the 6502-style dummy write of the original operand.
`ifndef OP_TST
`define OP_TST 4'h0
`endif
`ifndef OP_ASL
`define OP_ASL 4'h8
`endif
`ifndef OP_LSR
`define OP_LSR 4'h9
`endif
`ifndef OP_ROL
`define OP_ROL 4'hA
`endif
`ifndef OP_ROR
`define OP_ROR 4'hB
`endif
`ifndef OP_INC
`define OP_INC 4'hC
`endif
`ifndef OP_DEC
`define OP_DEC 4'hD
`endif

module rmw_unit #(
    parameter logic [2:0] ARG_SLOT = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    input  logic        bus_ready,
    output logic [3:0]  alu_op,
    output logic [2:0]  alu_arg_sel,
    output logic [7:0]  alu_operand,
    input  logic [7:0]  alu_result,
    input  logic [7:0]  alu_sr_data,
    output logic [7:0]  sr_flags,
    output logic [7:0]  sr_we
);

`ifdef RMW_DUMMY_WRITE_EN
    typedef enum logic [2:0] {IDLE, READ, EXEC, DUMMY, WRITE, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, FIN} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  operand_q, operand_d;
    logic [7:0]  result_q, result_d;
    logic [7:0]  flags_q, flags_d;
    logic        err_q, err_d;
    logic        req_ok, shift_op;

    always_comb begin
        req_ok = 1'b0;
        case (req_op)
            `OP_ASL, `OP_LSR, `OP_ROL, `OP_ROR, `OP_INC, `OP_DEC: req_ok = 1'b1;
            default: req_ok = 1'b0;
        endcase
    end

    // Shifts/rotates own N, Z and C; INC/DEC leave C untouched.
    always_comb begin
        shift_op = 1'b0;
        case (op_q)
            `OP_ASL, `OP_LSR, `OP_ROL, `OP_ROR: shift_op = 1'b1;
            default: shift_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= `OP_TST;
            addr_q    <= 16'h0000;
            operand_q <= 8'h00;
            result_q  <= 8'h00;
            flags_q   <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        operand_d = operand_q;
        result_d  = result_q;
        flags_d   = flags_q;
        err_d     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_dout  = 8'h00;
        alu_op    = `OP_TST;
        sr_flags  = 8'h00;
        sr_we     = 8'h00;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (req) begin
                    if (req_ok) begin
                        op_d    = req_op;
                        addr_d  = req_addr;
                        state_d = READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READ: begin
                bus_rd = 1'b1;
                if (bus_ready) begin
                    operand_d = bus_din;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                // Held a full cycle so an ALU latching on the negedge sees a settled op.
                alu_op   = op_q;
                result_d = alu_result;
                flags_d  = alu_sr_data;
`ifdef RMW_DUMMY_WRITE_EN
                state_d  = DUMMY;
`else
                state_d  = WRITE;
`endif
            end
`ifdef RMW_DUMMY_WRITE_EN
            DUMMY: begin
                bus_wr   = 1'b1;
                bus_dout = operand_q;
                if (bus_ready) state_d = WRITE;
            end
`endif
            WRITE: begin
                bus_wr   = 1'b1;
                bus_dout = result_q;
                if (bus_ready) state_d = FIN;
            end
            FIN: begin
                done     = 1'b1;
                sr_flags = flags_q;
                sr_we    = shift_op ? 8'h83 : 8'h82;
                state_d  = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign err         = err_q;
    assign bus_addr    = addr_q;
    assign alu_arg_sel = ARG_SLOT;
    assign alu_operand = operand_q;

endmodule

// File: tb/tb_rmw_unit.sv
// Directed bench for rmw_unit with a behavioural ALU and a write monitor.
// Latency is the 1-based cycle number after the req-sampling edge in which done is high.
module tb_rmw_unit;
    localparam logic [3:0] OP_TST = 4'h0, OP_ADD = 4'h1, OP_ASL = 4'h8, OP_LSR = 4'h9,
                           OP_ROL = 4'hA, OP_ROR = 4'hB, OP_INC = 4'hC, OP_DEC = 4'hD;

    logic        clk = 1'b0;
    logic        rst, req, bus_ready, cin;
    logic [3:0]  req_op;
    logic [15:0] req_addr;
    logic [7:0]  bus_din, alu_result, alu_sr_data;
    logic        busy, done, err, bus_rd, bus_wr;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout, alu_operand, sr_flags, sr_we;
    logic [3:0]  alu_op;
    logic [2:0]  alu_arg_sel;

    int checks = 0;
    int failures = 0;
    int wr_total = 0;
    int done_cnt = 0;
    logic [7:0]  wr_last = 8'h00, wr_prev = 8'h00;
    logic [15:0] wr_addr = 16'h0000;

    rmw_unit dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
        .busy(busy), .done(done), .err(err), .bus_addr(bus_addr), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_din(bus_din), .bus_dout(bus_dout), .bus_ready(bus_ready),
        .alu_op(alu_op), .alu_arg_sel(alu_arg_sel), .alu_operand(alu_operand),
        .alu_result(alu_result), .alu_sr_data(alu_sr_data), .sr_flags(sr_flags), .sr_we(sr_we)
    );

    always #5 clk = ~clk;

    // Reference ALU: flags are {N,V,0000,Z,C}; INC/DEC pass carry-in through.
    always_comb begin
        logic c;
        c = cin;
        case (alu_op)
            OP_ASL: begin alu_result = {alu_operand[6:0], 1'b0}; c = alu_operand[7]; end
            OP_LSR: begin alu_result = {1'b0, alu_operand[7:1]}; c = alu_operand[0]; end
            OP_ROL: begin alu_result = {alu_operand[6:0], cin};  c = alu_operand[7]; end
            OP_ROR: begin alu_result = {cin, alu_operand[7:1]};  c = alu_operand[0]; end
            OP_INC: alu_result = alu_operand + 8'h01;
            OP_DEC: alu_result = alu_operand - 8'h01;
            default: alu_result = alu_operand;
        endcase
        alu_sr_data = {alu_result[7], 1'b0, 4'b0000, (alu_result == 8'h00), c};
    end

    always @(posedge clk) begin
        if (bus_wr && bus_ready) begin
            wr_total <= wr_total + 1;
            wr_prev  <= wr_last;
            wr_last  <= bus_dout;
            wr_addr  <= bus_addr;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] addr,
                          input logic [7:0] din, input logic c, input int stall, input bit hold,
                          input logic [7:0] exp_res, input logic [7:0] exp_flags,
                          input logic [7:0] exp_we);
        int lat, wr0, exp_lat, exp_wr;
`ifdef RMW_DUMMY_WRITE_EN
        exp_lat = 5 + stall;
        exp_wr  = 2;
`else
        exp_lat = 4 + stall;
        exp_wr  = 1;
`endif
        bus_din = din; cin = c; bus_ready = (stall == 0); wr0 = wr_total;
        @(negedge clk);
        req = 1'b1; req_op = op; req_addr = addr;
        @(posedge clk); #1;
        lat = 1;
        // Held req with different op/addr must be ignored while busy.
        if (hold) begin req_op = OP_DEC; req_addr = 16'hBEEF; end else req = 1'b0;
        chk({tag, "_read_strobes"}, 32'({bus_rd, bus_wr, busy}), 32'b101);
        chk({tag, "_read_addr"}, 32'(bus_addr), 32'(addr));
        chk({tag, "_alu_op_idle"}, 32'(alu_op), 32'(OP_TST));
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; lat++; end
            chk({tag, "_stall_rd"}, 32'(bus_rd), 32'd1);
            bus_ready = 1'b1;
        end
        @(posedge clk); #1; lat++;
        chk({tag, "_exec_alu_op"}, 32'(alu_op), 32'(op));
        chk({tag, "_exec_operand"}, 32'(alu_operand), 32'(din));
        chk({tag, "_exec_no_strobe"}, 32'({bus_rd, bus_wr}), 32'd0);
        while (!done && lat < 30) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_sr_flags"}, 32'(sr_flags), 32'(exp_flags));
        chk({tag, "_sr_we"}, 32'(sr_we), 32'(exp_we));
        chk({tag, "_fin_strobes"}, 32'({bus_rd, bus_wr, busy}), 32'b001);
        chk({tag, "_write_count"}, 32'(wr_total - wr0), 32'(exp_wr));
        chk({tag, "_write_data"}, 32'(wr_last), 32'(exp_res));
        chk({tag, "_write_addr"}, 32'(wr_addr), 32'(addr));
`ifdef RMW_DUMMY_WRITE_EN
        chk({tag, "_dummy_data"}, 32'(wr_prev), 32'(din));
`endif
        @(posedge clk); #1;
        chk({tag, "_back_idle"}, 32'({busy, done}), 32'd0);
        req = 1'b0;
    endtask

    initial begin
        int wr0, dn0;
        rst = 1'b1; req = 1'b0; req_op = OP_TST; req_addr = 16'h0000;
        bus_din = 8'h00; bus_ready = 1'b1; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'({busy, done, err, bus_rd, bus_wr}), 32'd0);
        chk("reset_addr", 32'(bus_addr), 32'd0);
        chk("reset_dout", 32'(bus_dout), 32'd0);
        chk("reset_sr", 32'({sr_flags, sr_we}), 32'd0);
        chk("reset_operand", 32'(alu_operand), 32'd0);
        chk("reset_alu_op", 32'(alu_op), 32'(OP_TST));
        chk("arg_sel", 32'(alu_arg_sel), 32'd7);
        @(negedge clk); rst = 1'b0;

        run_op("asl",  OP_ASL, 16'h0200, 8'h81, 1'b0, 0, 1'b0, 8'h02, 8'h01, 8'h83);
        run_op("inc",  OP_INC, 16'h00FF, 8'hFF, 1'b0, 0, 1'b0, 8'h00, 8'h02, 8'h82);
        run_op("ror",  OP_ROR, 16'h0300, 8'h02, 1'b1, 3, 1'b1, 8'h81, 8'h80, 8'h83);
        run_op("dec",  OP_DEC, 16'h0010, 8'h01, 1'b0, 0, 1'b0, 8'h00, 8'h02, 8'h82);
        run_op("lsr",  OP_LSR, 16'h0400, 8'h01, 1'b0, 0, 1'b0, 8'h00, 8'h03, 8'h83);
        run_op("rol",  OP_ROL, 16'hFFFF, 8'h80, 1'b0, 0, 1'b0, 8'h00, 8'h03, 8'h83);

        // Unsupported op
        wr0 = wr_total;
        @(negedge clk); req = 1'b1; req_op = OP_ADD; req_addr = 16'h1234;
        @(posedge clk); #1; req = 1'b0;
        chk("err_pulse", 32'({err, busy, bus_rd, bus_wr}), 32'b1000);
        @(posedge clk); #1;
        chk("err_once", 32'({err, busy, bus_rd, bus_wr}), 32'd0);
        chk("err_no_write", 32'(wr_total - wr0), 32'd0);

        // Reset in the first write-strobe state (dummy write, or the only write)
        wr0 = wr_total; dn0 = done_cnt;
        bus_din = 8'h55; bus_ready = 1'b1;
        @(negedge clk); req = 1'b1; req_op = OP_ASL; req_addr = 16'h0500;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #1; bus_ready = 1'b0;
        @(posedge clk); #1;
        chk("abort_pre_wr", 32'({bus_wr, busy}), 32'b11);
        rst = 1'b1; #1;
        chk("abort_ctrl", 32'({bus_wr, bus_rd, busy, done}), 32'd0);
        chk("abort_addr", 32'(bus_addr), 32'd0);
        @(negedge clk); rst = 1'b0; bus_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - dn0), 32'd0);
        chk("abort_no_write", 32'(wr_total - wr0), 32'd0);
        chk("abort_idle", 32'({busy, bus_wr, bus_rd}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
